// File: rtl/cg_burst_gate.sv
// Multi-channel glitch-free clock gate.
// Each channel runs a small sequencer that drives the enable of a
// latch-based clock gate, either continuously or for an exact pulse count.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | gate closed, waiting for a START rise or an EN level
// ST_BURST | gate open, counting down the loaded burst length
// ST_CONT  | gate open for as long as EN stays high
module cg_burst_gate #(
    parameter int NCH       = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NCH-1:0]           EN,
    input  logic [NCH-1:0]           START,
    input  logic [NCH*CNT_WIDTH-1:0] BURST_LEN,
    output logic [NCH-1:0]           CK_OUT,
    output logic [NCH-1:0]           BUSY,
    output logic [NCH-1:0]           DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_CONT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t               st;
            logic [CNT_WIDTH-1:0] cnt;
            logic [CNT_WIDTH-1:0] len;
            logic                 en_q;
            logic                 done_q;
            logic                 start_d;
            logic                 start_rise;
            logic                 en_l;

            assign len        = BURST_LEN[gi*CNT_WIDTH +: CNT_WIDTH];
            assign start_rise = START[gi] & ~start_d;

            // Channel sequencer; START wins over EN, and the burst length is
            // only looked at when the counter is loaded.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    st      <= ST_IDLE;
                    cnt     <= CNT_ZERO;
                    en_q    <= 1'b0;
                    done_q  <= 1'b0;
                    start_d <= 1'b0;
                end else begin
                    start_d <= START[gi];
                    done_q  <= 1'b0;
                    case (st)
                        ST_IDLE: begin
                            if (start_rise) begin
                                if (len != CNT_ZERO) begin
                                    st   <= ST_BURST;
                                    cnt  <= len;
                                    en_q <= 1'b1;
                                end else begin
                                    done_q <= 1'b1;
                                end
                            end else if (EN[gi]) begin
                                st   <= ST_CONT;
                                en_q <= 1'b1;
                            end
                        end
                        ST_BURST: begin
                            cnt <= cnt - CNT_ONE;
                            if (cnt == CNT_ONE) begin
                                st     <= ST_IDLE;
                                en_q   <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                        ST_CONT: begin
                            if (!EN[gi]) begin
                                st   <= ST_IDLE;
                                en_q <= 1'b0;
                            end
                        end
                        default: begin
                            st   <= ST_IDLE;
                            en_q <= 1'b0;
                        end
                    endcase
                end
            end

            // Enable latch: only follows en_q while CLK is low, so the gated
            // clock can never be truncated or see a runt pulse.
            always_latch begin
                if (!CLK) en_l = en_q;
            end

            assign CK_OUT[gi] = CLK & en_l;
            assign BUSY[gi]   = (st != ST_IDLE);
            assign DONE[gi]   = done_q;
        end
    endgenerate

endmodule

// File: tb/tb_cg_burst_gate.sv
// Bench for cg_burst_gate: pulse-schedule reference model checked every
// cycle, directed scenarios with hand-computed pulse/DONE/BUSY counts,
// then a randomized phase.
module tb_cg_burst_gate;
    localparam int NCH = 4;
    localparam int CW  = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NCH-1:0]    EN;
    logic [NCH-1:0]    START;
    logic [NCH*CW-1:0] BURST_LEN;
    logic [NCH-1:0]    CK_OUT;
    logic [NCH-1:0]    BUSY;
    logic [NCH-1:0]    DONE;

    int errors = 0;
    int checks = 0;

    cg_burst_gate #(.NCH(NCH), .CNT_WIDTH(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .START     (START),
        .BURST_LEN (BURST_LEN),
        .CK_OUT    (CK_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: per channel a mode (0 idle, 1 burst, 2 continuous)
    // and, for bursts, the absolute cycle number of the last pulse edge.
    longint cyc = 0;
    int     m_mode [NCH];
    longint m_end  [NCH];
    bit     m_ps   [NCH];
    bit     m_done [NCH];
    bit     m_gate [NCH];
    bit     chk_on = 1'b0;

    int pulse_cnt [NCH];
    int busy_cnt  [NCH];
    int done_cnt  [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_end[c] = 0; m_ps[c] = 0; m_done[c] = 0; m_gate[c] = 0;
            pulse_cnt[c] = 0; busy_cnt[c] = 0; done_cnt[c] = 0;
        end
    end

    // Clock edges of the gated outputs may only coincide with CLK edges.
    always @(CK_OUT) begin
        if (chk_on) chk("ck_edge_align", $time % 5, 0);
    end

    initial begin : compare
        bit  gate_prev [NCH];
        bit  rise;
        int  len;
        forever begin
            @(posedge CLK);
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                gate_prev[c] = m_gate[c];
                if (RST) begin
                    m_mode[c] = 0;
                    m_ps[c]   = 0;
                    m_done[c] = 0;
                end else begin
                    rise      = START[c] && !m_ps[c];
                    m_ps[c]   = START[c];
                    m_done[c] = 0;
                    len       = int'(BURST_LEN[c*CW +: CW]);
                    if (m_mode[c] == 1) begin
                        if (cyc == m_end[c]) begin
                            m_mode[c] = 0;
                            m_done[c] = 1;
                        end
                    end else if (m_mode[c] == 2) begin
                        if (!EN[c]) m_mode[c] = 0;
                    end else if (rise) begin
                        if (len == 0) m_done[c] = 1;
                        else begin
                            m_mode[c] = 1;
                            m_end[c]  = cyc + len;
                        end
                    end else if (EN[c]) begin
                        m_mode[c] = 2;
                    end
                end
                m_gate[c] = (m_mode[c] != 0);
            end
            #2;
            if (chk_on) begin
                for (int c = 0; c < NCH; c++) begin
                    chk($sformatf("ck_out_high[%0d]", c), CK_OUT[c], gate_prev[c]);
                    chk($sformatf("busy[%0d]", c), BUSY[c], m_gate[c]);
                    chk($sformatf("done[%0d]", c), DONE[c], m_done[c]);
                    if (CK_OUT[c]) pulse_cnt[c]++;
                    if (BUSY[c])   busy_cnt[c]++;
                    if (DONE[c])   done_cnt[c]++;
                end
            end
            if (RST) chk_on = 1'b1;
            #5;
            if (chk_on) begin
                for (int c = 0; c < NCH; c++)
                    chk($sformatf("ck_out_low[%0d]", c), CK_OUT[c], 0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic zero_counts();
        for (int c = 0; c < NCH; c++) begin
            pulse_cnt[c] = 0; busy_cnt[c] = 0; done_cnt[c] = 0;
        end
    endtask

    task automatic expect_counts(input string tag, input int c, input int p, input int b, input int d);
        chk($sformatf("%s_pulses[%0d]", tag, c), pulse_cnt[c], p);
        chk($sformatf("%s_busy[%0d]", tag, c), busy_cnt[c], b);
        chk($sformatf("%s_done[%0d]", tag, c), done_cnt[c], d);
    endtask

    task automatic set_len(input int c, input int v);
        BURST_LEN[c*CW +: CW] = CW'(v);
    endtask

    initial begin : stim
        RST = 1'b1; EN = '1; START = '1; BURST_LEN = '0;

        // Reset held with every request active: nothing must come out.
        cycles(3);
        for (int c = 0; c < NCH; c++) expect_counts("reset", c, 0, 0, 0);
        RST = 1'b0; EN = '0; START = '0;
        cycles(2);

        // Burst of 5 on ch0.
        zero_counts();
        set_len(0, 5); START[0] = 1'b1;
        cycles(3);
        START[0] = 1'b0;
        cycles(8);
        expect_counts("burst5", 0, 5, 5, 1);

        // Zero-length burst: DONE only.
        zero_counts();
        set_len(2, 0); START[2] = 1'b1;
        cycles(2);
        START[2] = 1'b0;
        cycles(3);
        expect_counts("len0", 2, 0, 0, 1);

        // Maximum burst length.
        zero_counts();
        set_len(1, (1 << CW) - 1); START[1] = 1'b1;
        cycles(3);
        START[1] = 1'b0;
        cycles(260);
        expect_counts("lenmax", 1, (1 << CW) - 1, (1 << CW) - 1, 1);

        // Continuous mode for 10 sampled cycles.
        zero_counts();
        EN[1] = 1'b1;
        cycles(10);
        EN[1] = 1'b0;
        cycles(4);
        expect_counts("cont10", 1, 10, 10, 0);

        // START and EN together: 3-pulse burst, one idle gap, then continuous.
        zero_counts();
        set_len(2, 3); START[2] = 1'b1; EN[2] = 1'b1;
        cycles(10);
        START[2] = 1'b0; EN[2] = 1'b0;
        cycles(4);
        expect_counts("prio", 2, 9, 9, 1);

        // Back-to-back: a rise seen at the DONE posedge is ignored.
        zero_counts();
        set_len(0, 2); START[0] = 1'b1;
        cycles(1);
        START[0] = 1'b0;
        cycles(1);
        START[0] = 1'b1;
        cycles(6);
        START[0] = 1'b0;
        expect_counts("b2b", 0, 2, 2, 1);
        cycles(2);

        // Reset in the middle of a 20-pulse burst.
        zero_counts();
        set_len(0, 20); START[0] = 1'b1;
        cycles(7);
        RST = 1'b1;
        cycles(2);
        START[0] = 1'b0; RST = 1'b0;
        cycles(4);
        expect_counts("midrst", 0, 7, 7, 0);

        // Staggered bursts 1..4 on all channels, EN toggling on ch3 mid-burst.
        zero_counts();
        for (int c = 0; c < NCH; c++) set_len(c, c + 1);
        for (int c = 0; c < NCH; c++) begin
            START[c] = 1'b1;
            cycles(1);
        end
        EN[3] = 1'b1; cycles(1);
        EN[3] = 1'b0; cycles(1);
        EN[3] = 1'b1; cycles(1);
        EN[3] = 1'b0;
        cycles(10);
        START = '0;
        cycles(3);
        for (int c = 0; c < NCH; c++) expect_counts("stagger", c, c + 1, c + 1, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0)  START[c] = ~START[c];
                if ($urandom_range(0, 15) == 0) EN[c] = ~EN[c];
                if ($urandom_range(0, 3) == 0)
                    set_len(c, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12)));
            end
            RST = ($urandom_range(0, 199) == 0);
            cycles(1);
        end
        RST = 1'b0; EN = '0; START = '0;
        cycles(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
